// File: rtl/uart_cpu_jtag_debug_cmd_sync.sv
// Moves virtual-JTAG update-DR/update-IR events from the tck domain into clk,
// queues {ir, data} commands in a small circular buffer and tracks the current IR.
module uart_cpu_jtag_debug_cmd_sync #(
  parameter int DW          = 38,
  parameter int IRW         = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 4,
  parameter int ACT_BIT     = 37
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           vs_udr,
  input  logic                           vs_uir,
  input  logic [IRW-1:0]                 ir_in,
  input  logic [DW-1:0]                  sr,
  input  logic                           cmd_ready,
  input  logic                           ovf_clr,
  output logic                           cmd_valid,
  output logic [IRW-1:0]                 cmd_ir,
  output logic [DW-1:0]                  cmd_jdo,
  output logic                           cmd_action,
  output logic                           ir_update,
  output logic [IRW-1:0]                 ir_cur,
  output logic [$clog2(DEPTH+1)-1:0]     fifo_level,
  output logic                           overflow,
  output logic                           armed
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam int EW = IRW + DW;

  logic [SYNC_STAGES-1:0] udr_sync_q, udr_sync_d;
  logic [SYNC_STAGES-1:0] uir_sync_q, uir_sync_d;
  logic                   udr_hist_q, udr_hist_d;
  logic                   uir_hist_q, uir_hist_d;
  logic [2:0]             arm_cnt_q, arm_cnt_d;
  logic                   armed_q, armed_d;
  logic                   ir_update_q, ir_update_d;
  logic [IRW-1:0]         ir_cur_q, ir_cur_d;
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          count_q, count_d;
  logic                   overflow_q, overflow_d;
  logic [EW-1:0]          mem_q [DEPTH];

  logic udr_rise, uir_rise, push_req, pop, full, do_push, drop;
  logic [EW-1:0] head;

  assign udr_rise = udr_sync_q[SYNC_STAGES-1] & ~udr_hist_q;
  assign uir_rise = uir_sync_q[SYNC_STAGES-1] & ~uir_hist_q;
  assign push_req = udr_rise & armed_q;
  assign full     = (count_q == LW'(DEPTH));
  assign pop      = cmd_valid & cmd_ready;
  // A full queue still accepts a push when the head leaves on the same edge.
  assign do_push  = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  always_comb begin
    udr_sync_d  = {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
    uir_sync_d  = {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
    udr_hist_d  = udr_sync_q[SYNC_STAGES-1];
    uir_hist_d  = uir_sync_q[SYNC_STAGES-1];
    arm_cnt_d   = arm_cnt_q;
    armed_d     = armed_q;
    ir_update_d = uir_rise & armed_q;
    ir_cur_d    = ir_cur_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;

    // Levels already high at reset release must not look like fresh rises.
    if (!armed_q) begin
      if (arm_cnt_q == 3'(SYNC_STAGES)) armed_d = 1'b1;
      else                               arm_cnt_d = arm_cnt_q + 3'd1;
    end

    if (uir_rise && armed_q) ir_cur_d = ir_in;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PW'(1);

    case ({do_push, pop})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase

    if (drop)         overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      udr_sync_q  <= '0;
      uir_sync_q  <= '0;
      udr_hist_q  <= 1'b0;
      uir_hist_q  <= 1'b0;
      arm_cnt_q   <= '0;
      armed_q     <= 1'b0;
      ir_update_q <= 1'b0;
      ir_cur_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      udr_sync_q  <= udr_sync_d;
      uir_sync_q  <= uir_sync_d;
      udr_hist_q  <= udr_hist_d;
      uir_hist_q  <= uir_hist_d;
      arm_cnt_q   <= arm_cnt_d;
      armed_q     <= armed_d;
      ir_update_q <= ir_update_d;
      ir_cur_q    <= ir_cur_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage holds data only; occupancy is tracked by count_q so it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= {ir_in, sr};
  end

  assign head       = mem_q[rd_ptr_q];
  assign cmd_valid  = (count_q != '0);
  assign cmd_ir     = cmd_valid ? head[EW-1:DW] : '0;
  assign cmd_jdo    = cmd_valid ? head[DW-1:0]  : '0;
  assign cmd_action = cmd_valid & head[ACT_BIT];
  assign ir_update  = ir_update_q;
  assign ir_cur     = ir_cur_q;
  assign fifo_level = count_q;
  assign overflow   = overflow_q;
  assign armed      = armed_q;

endmodule

// File: tb/tb_uart_cpu_jtag_debug_cmd_sync.sv
// Directed bench for uart_cpu_jtag_debug_cmd_sync: stimulus driven and outputs
// sampled on the falling edge of clk.
module tb_uart_cpu_jtag_debug_cmd_sync;

  logic        clk, reset, vs_udr, vs_uir, cmd_ready, ovf_clr;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic        cmd_valid, cmd_action, ir_update, overflow, armed;
  logic [1:0]  cmd_ir, ir_cur;
  logic [37:0] cmd_jdo;
  logic [2:0]  fifo_level;

  int n_chk  = 0;
  int n_fail = 0;

  uart_cpu_jtag_debug_cmd_sync dut (
    .clk(clk), .reset(reset), .vs_udr(vs_udr), .vs_uir(vs_uir),
    .ir_in(ir_in), .sr(sr), .cmd_ready(cmd_ready), .ovf_clr(ovf_clr),
    .cmd_valid(cmd_valid), .cmd_ir(cmd_ir), .cmd_jdo(cmd_jdo),
    .cmd_action(cmd_action), .ir_update(ir_update), .ir_cur(ir_cur),
    .fifo_level(fifo_level), .overflow(overflow), .armed(armed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_cmd(input logic [1:0] ir, input logic [37:0] d);
    ir_in = ir; sr = d; vs_udr = 1'b1;
    step(3);
    vs_udr = 1'b0;
    step(3);
  endtask

  task automatic pop_chk(input string tag, input logic [1:0] ir, input logic [37:0] d);
    logic act;
    act = d[37];
    chk({tag, "_valid"}, 64'(cmd_valid), 64'd1);
    chk({tag, "_ir"}, 64'(cmd_ir), 64'(ir));
    chk({tag, "_jdo"}, 64'(cmd_jdo), 64'(d));
    chk({tag, "_act"}, 64'(cmd_action), 64'(act));
    cmd_ready = 1'b1;
    step(1);
    cmd_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; vs_udr = 1'b0; vs_uir = 1'b0; cmd_ready = 1'b0; ovf_clr = 1'b0;
    ir_in = '0; sr = '0;
    step(1);
    chk("rst_valid", 64'(cmd_valid), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_armed", 64'(armed), 64'd0);
    chk("rst_ircur", 64'(ir_cur), 64'd0);
    chk("rst_irupd", 64'(ir_update), 64'd0);
    chk("rst_jdo", 64'(cmd_jdo), 64'd0);
    chk("rst_act", 64'(cmd_action), 64'd0);
    reset = 1'b0;
    step(2);
    chk("arm_early", 64'(armed), 64'd0);
    step(1);
    chk("arm_on", 64'(armed), 64'd1);

    // Single command, latency and held-level behaviour
    ir_in = 2'b01; sr = 38'h20_0000_1234; vs_udr = 1'b1;
    step(2);
    chk("lat_not_yet", 64'(cmd_valid), 64'd0);
    step(1);
    chk("lat_valid", 64'(cmd_valid), 64'd1);
    chk("lat_ir", 64'(cmd_ir), 64'd1);
    chk("lat_act", 64'(cmd_action), 64'd1);
    chk("lat_jdo", 64'(cmd_jdo), 64'h20_0000_1234);
    chk("lat_level", 64'(fifo_level), 64'd1);
    step(5);
    chk("held_level", 64'(fifo_level), 64'd1);
    vs_udr = 1'b0;
    step(3);
    pop_chk("p0", 2'd1, 38'h20_0000_1234);
    chk("p0_empty", 64'(fifo_level), 64'd0);
    chk("p0_act0", 64'(cmd_action), 64'd0);

    // Overflow: five pushes into a four-deep queue
    push_cmd(2'd0, 38'h20_0000_0001);
    push_cmd(2'd1, 38'h00_0000_0002);
    push_cmd(2'd2, 38'h3F_FFFF_FFFF);
    push_cmd(2'd3, 38'h10_0000_0004);
    chk("full_level", 64'(fifo_level), 64'd4);
    chk("full_noovf", 64'(overflow), 64'd0);
    push_cmd(2'd0, 38'h20_0000_0005);
    chk("drop_level", 64'(fifo_level), 64'd4);
    chk("drop_ovf", 64'(overflow), 64'd1);
    pop_chk("q0", 2'd0, 38'h20_0000_0001);
    pop_chk("q1", 2'd1, 38'h00_0000_0002);
    pop_chk("q2", 2'd2, 38'h3F_FFFF_FFFF);
    pop_chk("q3", 2'd3, 38'h10_0000_0004);
    chk("q_empty", 64'(cmd_valid), 64'd0);
    chk("q_ovf_sticky", 64'(overflow), 64'd1);
    ovf_clr = 1'b1; step(1); ovf_clr = 1'b0;
    chk("ovf_clr", 64'(overflow), 64'd0);

    // Full queue: push coinciding with pop, then drop coinciding with ovf_clr
    push_cmd(2'd1, 38'h01_1111_1111);
    push_cmd(2'd2, 38'h22_2222_2222);
    push_cmd(2'd3, 38'h03_3333_3333);
    push_cmd(2'd0, 38'h24_4444_4444);
    ir_in = 2'd2; sr = 38'h15_5555_5555; vs_udr = 1'b1;
    step(2);
    cmd_ready = 1'b1; step(1); cmd_ready = 1'b0;
    chk("pp_level", 64'(fifo_level), 64'd4);
    chk("pp_ovf", 64'(overflow), 64'd0);
    chk("pp_head", 64'(cmd_jdo), 64'h22_2222_2222);
    vs_udr = 1'b0; step(3);
    ir_in = 2'd3; sr = 38'h06_6666_6666; vs_udr = 1'b1;
    step(2);
    ovf_clr = 1'b1; step(1); ovf_clr = 1'b0;
    chk("setwin_ovf", 64'(overflow), 64'd1);
    chk("setwin_level", 64'(fifo_level), 64'd4);
    vs_udr = 1'b0; step(3);
    ovf_clr = 1'b1; step(1); ovf_clr = 1'b0;
    chk("clr2_ovf", 64'(overflow), 64'd0);
    pop_chk("f1", 2'd2, 38'h22_2222_2222);
    pop_chk("f2", 2'd3, 38'h03_3333_3333);
    pop_chk("f3", 2'd0, 38'h24_4444_4444);
    pop_chk("f4", 2'd2, 38'h15_5555_5555);
    chk("f_empty", 64'(fifo_level), 64'd0);

    // Simultaneous udr and uir rises
    ir_in = 2'b10; sr = 38'h00_0000_00AB; vs_udr = 1'b1; vs_uir = 1'b1;
    step(2);
    chk("both_upd_early", 64'(ir_update), 64'd0);
    step(1);
    chk("both_upd", 64'(ir_update), 64'd1);
    chk("both_ircur", 64'(ir_cur), 64'd2);
    chk("both_cmdir", 64'(cmd_ir), 64'd2);
    chk("both_level", 64'(fifo_level), 64'd1);
    step(1);
    chk("both_upd_pulse", 64'(ir_update), 64'd0);
    chk("both_level2", 64'(fifo_level), 64'd1);
    vs_udr = 1'b0; vs_uir = 1'b0;
    step(3);

    // Asynchronous reset with three commands queued, levels high at release
    push_cmd(2'd1, 38'h00_0000_0011);
    push_cmd(2'd3, 38'h00_0000_0022);
    chk("pre_rst_level", 64'(fifo_level), 64'd3);
    reset = 1'b1;
    #1;
    chk("arst_valid", 64'(cmd_valid), 64'd0);
    chk("arst_level", 64'(fifo_level), 64'd0);
    chk("arst_ircur", 64'(ir_cur), 64'd0);
    vs_udr = 1'b1; vs_uir = 1'b1;
    step(2);
    reset = 1'b0;
    step(2);
    chk("rel_armed_early", 64'(armed), 64'd0);
    step(1);
    chk("rel_armed", 64'(armed), 64'd1);
    chk("rel_nopush", 64'(fifo_level), 64'd0);
    chk("rel_noupd", 64'(ir_update), 64'd0);
    step(3);
    chk("rel_nopush2", 64'(cmd_valid), 64'd0);
    chk("rel_ircur", 64'(ir_cur), 64'd0);
    vs_udr = 1'b0; vs_uir = 1'b0;
    step(3);
    push_cmd(2'd3, 38'h2A_BCDE_F012);
    chk("rel_push_level", 64'(fifo_level), 64'd1);
    pop_chk("rel_push", 2'd3, 38'h2A_BCDE_F012);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_cpu_jtag_debug_cmd_sync.md
UART_CPU_JTAG_DEBUG_CMD_SYNC -- requirements
Module: uart_cpu_jtag_debug_cmd_sync

Interface
REQ-001 Parameter DW, default 38: width of the shifted debug data word (sr, cmd_jdo).
REQ-002 Parameter IRW, default 2: width of the virtual-JTAG instruction register.
REQ-003 Parameter SYNC_STAGES, default 2, legal 2..4: synchronizer flop count on vs_udr and vs_uir.
REQ-004 Parameter DEPTH, default 4, power of two, 2..16: command queue depth.
REQ-005 Parameter ACT_BIT, default 37, range 0..DW-1: data bit that selects action versus no-action.
REQ-006 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-007 clk  in  1  system clock; all state updates on its rising edge.
REQ-008 reset  in  1  asynchronous active-high reset.
REQ-009 vs_udr  in  1  update-DR level from the tck domain; asynchronous to clk.
REQ-010 vs_uir  in  1  update-IR level from the tck domain; asynchronous to clk.
REQ-011 ir_in  in  IRW  instruction from the tck domain; quasi-static, stable for more than SYNC_STAGES+2 clk cycles around each update.
REQ-012 sr  in  DW  shift-register contents from the tck domain; quasi-static under the same rule as ir_in.
REQ-013 cmd_ready  in  1  consumer accepts the head command.
REQ-014 ovf_clr  in  1  single-cycle clear for overflow.
REQ-015 cmd_valid  out  1  queue head is valid.
REQ-016 cmd_ir  out  IRW  instruction of the head command.
REQ-017 cmd_jdo  out  DW  data of the head command.
REQ-018 cmd_action  out  1  equals cmd_jdo[ACT_BIT] when cmd_valid is high, else 0.
REQ-019 ir_update  out  1  one-cycle pulse on each synchronized vs_uir rise.
REQ-020 ir_cur  out  IRW  ir_in value latched at the last ir_update.
REQ-021 fifo_level  out  clog2(DEPTH+1)  number of queued commands.
REQ-022 overflow  out  1  sticky flag set when a command is dropped.
REQ-023 armed  out  1  high once post-reset edge detection is enabled.

Function
REQ-024 Each of vs_udr and vs_uir SHALL pass through SYNC_STAGES flops followed by one history flop, with rise = last stage & ~history.
REQ-025 An arm counter SHALL count SYNC_STAGES+1 cycles after reset release; armed rises when it expires, and rises detected while armed=0 SHALL be ignored.
REQ-026 A udr rise SHALL push {ir_in, sr} into the queue on the following edge; cmd_valid rises SYNC_STAGES+1 edges after the first edge that samples vs_udr high.
REQ-027 A uir rise SHALL produce ir_update high for exactly one cycle and load ir_cur with ir_in on the same edge.
REQ-028 The queue SHALL be a circular buffer with read and write pointers that wrap modulo DEPTH, and the head SHALL be driven combinationally from storage.
REQ-029 A pop SHALL occur on any edge where cmd_valid and cmd_ready are both high; cmd_ready while empty has no effect.
REQ-030 When the queue is full and a push coincides with a pop, both SHALL proceed, fifo_level stays DEPTH and overflow is not set.
REQ-031 When the queue is full and a push occurs without a pop, the command SHALL be dropped, the queue left unchanged, and overflow set.
REQ-032 On an edge where ovf_clr is high and a drop occurs, overflow SHALL remain set (set wins).
REQ-033 Simultaneous udr and uir rises SHALL both take effect; the pushed command uses ir_in, not the prior ir_cur.
REQ-034 Each vs_udr level held high SHALL yield exactly one push regardless of duration.

Reset
REQ-035 On reset assertion, all synchronizer, history, arm, pointer and storage-valid state SHALL clear immediately; queued commands are discarded.
REQ-036 During reset: cmd_valid=0, cmd_action=0, ir_update=0, ir_cur=0, fifo_level=0, overflow=0, armed=0; cmd_jdo and cmd_ir=0.
REQ-037 A vs_udr or vs_uir level already high at reset release SHALL produce no command and no ir_update.

Verification
REQ-038 Defaults; ir_in=2'b01, sr=38'h20_0000_1234, raise vs_udr -> cmd_valid 3 edges later, cmd_ir=1, cmd_action=1, fifo_level=1.
REQ-039 cmd_ready=0; 5 distinct udr pulses -> fifo_level=4, overflow=1, then 4 pops return the first 4 values in order.
REQ-040 Full queue, cmd_ready=1 and a udr rise on the same edge -> fifo_level stays 4, overflow stays 0, the new value appears last.
REQ-041 vs_udr held high through reset release -> no push, armed rises after 3 cycles; the next low-to-high transition pushes one command.
REQ-042 Reset asserted with 3 commands queued -> cmd_valid=0 and fifo_level=0 asynchronously; after release, ir_cur=0.
REQ-043 udr and uir rise together with ir_in=2'b10 -> one push with cmd_ir=2, ir_update pulse, ir_cur=2.
